alu_op_issuer: RTL and testbench
================================

// Module: alu_op_issuer
// PURPOSE
//  Command-side front end of the 16-bit ALU result mux. Accepts binary-coded
//  ALU commands over a valid/ready handshake and drives the mux's 12-bit
//  one-hot select and the operands. After a programmable settle time it
//  captures the selected 16-bit result and returns it over a valid/ready
//  response channel. Keeps an accumulator so commands can chain on the prior result.
// PARAMETERS
//  SETTLE_CYCLES  1   cycles alu_sel is held before alu_res is sampled (legal 1..15)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   issuer can accept a command (1 only in IDLE)
//  cmd_op       in   4   binary opcode (encoding below)
//  cmd_use_acc  in   1   1: operand A = accumulator; 0: operand A = cmd_a
//  cmd_a        in   16  operand A
//  cmd_b        in   16  operand B
//  alu_sel      out  12  one-hot select to the result mux; 0 when not BUSY
//  alu_a        out  16  latched operand A to the ALU units
//  alu_b        out  16  latched operand B to the ALU units
//  alu_res      in   16  selected result returned by the mux
//  resp_valid   out  1   response present
//  resp_ready   in   1   consumer accepts the response
//  resp_data    out  16  captured result
//  resp_err     out  1   1 = illegal opcode; resp_data = 0
// BEHAVIOUR
//  Opcode -> alu_sel: 0 AND 12'h001, 1 OR 12'h002, 2 NOT 12'h004,
//   3 XOR 12'h008, 4 NAND 12'h010, 5 NOR 12'h020, 6 XNOR 12'h040,
//   7 ADD 12'h080, 8 SUB 12'h100, 9 SHRIGHT 12'h200, 10 SHLEFT 12'h400,
//   11 CLEAR 12'h800. Opcodes 12-15 are illegal.
//  Reset (async, takes effect immediately, including mid-operation): state
//   IDLE, alu_sel=0, alu_a=0, alu_b=0, resp_valid=0, resp_data=0,
//   resp_err=0, acc=0, counter=0. cmd_ready=1 while in IDLE.
//  FSM states: IDLE, BUSY, RESP. cmd_ready=(state==IDLE).
//  IDLE: on cmd_valid&cmd_ready at edge N, latch op, alu_a (acc if
//   cmd_use_acc, else cmd_a), and alu_b=cmd_b.
//   Legal op: go to BUSY and load counter=SETTLE_CYCLES-1.
//   Illegal op: go to RESP with resp_err=1 and resp_data=0. acc, alu_a and
//   alu_b are not updated. alu_sel is never asserted.
//  BUSY: alu_sel=one-hot(op), registered, valid from cycle N+1. alu_a and
//   alu_b stay stable. The counter decrements each cycle. When counter==0:
//   resp_data<=alu_res and acc<=alu_res; CLEAR instead forces resp_data<=0
//   and acc<=0 regardless of alu_res. resp_err<=0. Then go to RESP.
//   alu_sel is held exactly SETTLE_CYCLES cycles.
//  RESP: resp_valid=1. resp_data and resp_err are stable until
//   resp_valid&resp_ready. On that edge go to IDLE; resp_valid drops next cycle.
//   cmd_valid is ignored in BUSY and RESP (no queueing).
//  Latency: legal command accepted at edge N -> resp_valid high from cycle
//   N+1+SETTLE_CYCLES. Illegal command -> resp_valid high from cycle N+1.
//  SUB is issued as SUB. The add/sub unit derives direction from alu_sel.
//  Width: all data paths are 16 bits. Result bits come from alu_res unchanged.
// TESTING
//  1 ADD, SETTLE=1: op=7, a=0x0003, b=0x0004, mux model returns 0x0007 ->
//    alu_sel=12'h080 for 1 cycle at N+1; resp_valid at N+2; data=0x0007; err=0.
//  2 SETTLE=3, op=8 SUB, a=0x0010, b=0x0001 -> alu_sel=12'h100 for 3
//    cycles; resp_valid at N+4; data=0x000F.
//  3 Illegal op=13 -> alu_sel stays 0; resp_valid at N+1; err=1;
//    data=0x0000; acc unchanged.
//  4 Chain: after result 0x0007, op=10 SHLEFT with use_acc=1 ->
//    alu_a=0x0007, alu_sel=12'h400; response 0x000E is also stored in acc.
//  5 Backpressure: hold resp_ready=0 for 5 cycles and pulse cmd_valid ->
//    resp_valid/data stay stable, cmd_ready=0, command not accepted.
//  6 CLEAR op=11 with mux returning 0xFFFF -> resp_data=0 and acc=0. Reset
//    asserted mid-BUSY -> alu_sel=0 and resp_valid=0 immediately; IDLE after release.

Source files
------------

// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_issuer
// Brief    : Command front end for the 16-bit ALU result mux. It issues a
//            one-hot select, waits a settle time, then returns the captured
//            result and keeps it in an accumulator for chained commands.
// Revision : 1.0
// ============================================================================
module alu_op_issuer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_use_acc,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [11:0] alu_sel,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_res,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam int         CLEAR_BIT   = 11;

    state_t      state;
    logic [3:0]  count;
    logic [15:0] acc;
    logic        op_legal;

    assign cmd_ready = (state == IDLE);
    assign op_legal  = (cmd_op < 4'd12);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            acc        <= '0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (op_legal) begin
                            alu_sel <= 12'd1 << cmd_op;
                            alu_a   <= cmd_use_acc ? acc : cmd_a;
                            alu_b   <= cmd_b;
                            count   <= SETTLE_LOAD;
                            state   <= BUSY;
                        end else begin
                            // Illegal opcodes never touch the ALU or the accumulator.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            state      <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        // CLEAR zeroes the result regardless of what the mux returns.
                        if (alu_sel[CLEAR_BIT]) begin
                            resp_data <= '0;
                            acc       <= '0;
                        end else begin
                            resp_data <= alu_res;
                            acc       <= alu_res;
                        end
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        alu_sel    <= '0;
                        state      <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    alu_sel    <= '0;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_issuer
// Brief    : Scoreboard bench for alu_op_issuer; two instances (settle 1 and 3)
//            exercised in turn against a behavioural ALU reference.
// Revision : 1.0
// ============================================================================
module tb_alu_op_issuer;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [11:0] sel;
        logic [15:0] a;
        int          lat;
        time         t_acc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic [3:0]  cmd_op      [2];
    logic        cmd_use_acc [2];
    logic [15:0] cmd_a       [2];
    logic [15:0] cmd_b       [2];
    logic [11:0] alu_sel     [2];
    logic [15:0] alu_a       [2];
    logic [15:0] alu_b       [2];
    logic [15:0] alu_res     [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [15:0] resp_data   [2];
    logic        resp_err    [2];

    int          total = 0;
    int          bad   = 0;
    int          settle_of [2] = '{1, 3};
    logic [15:0] acc_m [2];
    exp_t        sb [$];
    bit          hold_rr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_op_issuer #(.SETTLE_CYCLES((g == 0) ? 1 : 3)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .cmd_valid   (cmd_valid[g]),
            .cmd_ready   (cmd_ready[g]),
            .cmd_op      (cmd_op[g]),
            .cmd_use_acc (cmd_use_acc[g]),
            .cmd_a       (cmd_a[g]),
            .cmd_b       (cmd_b[g]),
            .alu_sel     (alu_sel[g]),
            .alu_a       (alu_a[g]),
            .alu_b       (alu_b[g]),
            .alu_res     (alu_res[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_data   (resp_data[g]),
            .resp_err    (resp_err[g])
        );

        // Result mux model: CLEAR deliberately returns all ones.
        always_comb begin
            alu_res[g] = 16'h0000;
            case (alu_sel[g])
                12'h001: alu_res[g] = alu_a[g] & alu_b[g];
                12'h002: alu_res[g] = alu_a[g] | alu_b[g];
                12'h004: alu_res[g] = ~alu_a[g];
                12'h008: alu_res[g] = alu_a[g] ^ alu_b[g];
                12'h010: alu_res[g] = ~(alu_a[g] & alu_b[g]);
                12'h020: alu_res[g] = ~(alu_a[g] | alu_b[g]);
                12'h040: alu_res[g] = ~(alu_a[g] ^ alu_b[g]);
                12'h080: alu_res[g] = alu_a[g] + alu_b[g];
                12'h100: alu_res[g] = alu_a[g] - alu_b[g];
                12'h200: alu_res[g] = alu_a[g] >> 1;
                12'h400: alu_res[g] = alu_a[g] << 1;
                12'h800: alu_res[g] = 16'hFFFF;
                default: alu_res[g] = 16'hDEAD;
            endcase
        end
    end

    function automatic logic [15:0] ref_result(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            0:  return a & b;
            1:  return a | b;
            2:  return ~a;
            3:  return a ^ b;
            4:  return ~(a & b);
            5:  return ~(a | b);
            6:  return ~(a ^ b);
            7:  return a + b;
            8:  return a - b;
            9:  return a >> 1;
            10: return a << 1;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Consumer side: random backpressure unless explicitly held off.
    initial begin
        resp_ready[0] = 1'b0;
        resp_ready[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                resp_ready[d] = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    int          sel_cnt  [2] = '{0, 0};
    logic [11:0] last_sel [2];
    logic [15:0] last_a   [2];
    bit          in_resp  [2] = '{0, 0};
    logic [15:0] held_d   [2];
    logic        held_e   [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                sel_cnt[d]  = 0;
                last_sel[d] = '0;
                last_a[d]   = '0;
                in_resp[d]  = 0;
            end else begin
                if (alu_sel[d] != 12'h000) begin
                    sel_cnt[d]++;
                    last_sel[d] = alu_sel[d];
                    last_a[d]   = alu_a[d];
                end
                if (resp_valid[d]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_response", 32'(resp_valid[d]), 32'd0);
                    end else begin
                        if (!in_resp[d]) begin
                            check("latency", 32'(int'(($time - sb[0].t_acc - 5) / 10)), 32'(sb[0].lat));
                            check("sel_cycles", 32'(sel_cnt[d]), 32'(sb[0].lat));
                            check("alu_sel", 32'(last_sel[d]), 32'(sb[0].sel));
                            if (sb[0].sel != 12'h000)
                                check("alu_a", 32'(last_a[d]), 32'(sb[0].a));
                            in_resp[d] = 1;
                            held_d[d]  = resp_data[d];
                            held_e[d]  = resp_err[d];
                        end else begin
                            check("resp_data_stable", 32'(resp_data[d]), 32'(held_d[d]));
                            check("resp_err_stable", 32'(resp_err[d]), 32'(held_e[d]));
                        end
                        if (resp_ready[d]) begin
                            check("resp_data", 32'(resp_data[d]), 32'(sb[0].data));
                            check("resp_err", 32'(resp_err[d]), 32'(sb[0].err));
                            void'(sb.pop_front());
                            in_resp[d]  = 0;
                            sel_cnt[d]  = 0;
                            last_sel[d] = '0;
                            last_a[d]   = '0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input int op, input bit ua, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          guard;
        logic [15:0] opa;
        guard = 0;
        while (!cmd_ready[d] && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) check("cmd_ready_timeout", 32'(cmd_ready[d]), 32'd1);
        cmd_valid[d]   = 1'b1;
        cmd_op[d]      = 4'(op);
        cmd_use_acc[d] = ua;
        cmd_a[d]       = a;
        cmd_b[d]       = b;
        @(posedge clk);
        e.t_acc = $time;
        #1;
        cmd_valid[d] = 1'b0;
        opa = ua ? acc_m[d] : a;
        if (op < 12) begin
            e.err    = 1'b0;
            e.data   = ref_result(op, opa, b);
            e.sel    = 12'd1 << op;
            e.lat    = settle_of[d];
            acc_m[d] = e.data;
        end else begin
            e.err  = 1'b1;
            e.data = 16'h0000;
            e.sel  = 12'h000;
            e.lat  = 0;
        end
        e.a = opa;
        sb.push_back(e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] bp_data;
        int          guard;
        reset = 1'b1;
        acc_m = '{16'h0, 16'h0};
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 0; cmd_op[d] = 0; cmd_use_acc[d] = 0; cmd_a[d] = 0; cmd_b[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_alu_sel", 32'(alu_sel[d]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_resp_data", 32'(resp_data[d]), 32'd0);
            check("rst_resp_err", 32'(resp_err[d]), 32'd0);
            check("rst_alu_a", 32'(alu_a[d]), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
        end
        reset = 1'b0;

        // Settle of 1: directed cases then random traffic.
        issue(0, 7, 0, 16'h0003, 16'h0004);
        issue(0, 10, 1, 16'hAAAA, 16'h0000);
        issue(0, 13, 0, 16'h1234, 16'h5678);
        issue(0, 7, 1, 16'h0000, 16'h0001);
        issue(0, 11, 0, 16'h1234, 16'h4321);
        issue(0, 1, 1, 16'hFFFF, 16'h0000);
        drain();

        hold_rr = 1;
        issue(0, 3, 0, 16'h00F0, 16'h0FF0);
        guard = 0;
        while (!resp_valid[0] && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
        bp_data = resp_data[0];
        for (int i = 0; i < 5; i++) begin
            cmd_valid[0] = 1'b1;
            cmd_op[0]    = 4'd7;
            @(posedge clk);
            #1;
            check("bp_cmd_ready", 32'(cmd_ready[0]), 32'd0);
            check("bp_valid_hold", 32'(resp_valid[0]), 32'd1);
            check("bp_data_hold", 32'(resp_data[0]), 32'(bp_data));
        end
        cmd_valid[0] = 1'b0;
        hold_rr = 0;
        drain();

        for (int i = 0; i < 40; i++)
            issue(0, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        drain();

        // Settle of 3.
        issue(1, 8, 0, 16'h0010, 16'h0001);
        for (int i = 0; i < 30; i++)
            issue(1, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        drain();

        // Asynchronous reset while BUSY.
        issue(1, 7, 0, 16'h0100, 16'h0023);
        check("pre_reset_sel", 32'(alu_sel[1]), 32'h080);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_sel", 32'(alu_sel[1]), 32'd0);
        check("async_rst_valid", 32'(resp_valid[1]), 32'd0);
        sb.delete();
        acc_m = '{16'h0, 16'h0};
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(cmd_ready[1]), 32'd1);
        issue(1, 7, 1, 16'hFFFF, 16'h0005);
        drain();
        repeat (5) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
